// File: rtl/serial_adder_pkg.sv
// rtl/serial_adder_pkg.sv - shared types and constants for the bit-serial adder
// Purpose : FSM state encoding, default operand width and counter-width helper.
// Ports   : none (package).
// Config  : SERIAL_ADDER_SUB_EN (used by serial_adder_ctrl) adds subtraction.
package serial_adder_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADD  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int DEFAULT_WIDTH = 8;

   // Bit counter only has to reach WIDTH-1, so $clog2(WIDTH) bits suffice.
   function automatic int cnt_width(input int w);
      return (w < 2) ? 1 : $clog2(w);
   endfunction

   localparam int DEFAULT_CNT_W = cnt_width(DEFAULT_WIDTH);

endpackage

// File: rtl/full_adder.sv
// rtl/full_adder.sv - single-bit full adder
// Purpose : combinational one-bit add used by the serial adder datapath.
// Ports   : a, b, ci (inputs); s (sum bit), co (carry-out).
module full_adder (
   input  logic a,
   input  logic b,
   input  logic ci,
   output logic s,
   output logic co
);

   assign s  = a ^ b ^ ci;
   assign co = (a & b) | (a & ci) | (b & ci);

endmodule

// File: rtl/serial_adder_ctrl.sv
// rtl/serial_adder_ctrl.sv - bit-serial adder controller around one full_adder
// Purpose : adds two WIDTH-bit operands LSB first, one bit per clock.
// Ports   : clk, rst_n (async active-low); start, a, b, cin sampled in IDLE;
//           busy (ADD or DONE), done (one-cycle pulse), sum/cout (registered).
// Config  : SERIAL_ADDER_SUB_EN adds input sub; sub=1 computes a-b with
//           cout=1 meaning no borrow. Undefined: addition only, no sub port.
module serial_adder_ctrl
   import serial_adder_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
   input  logic             sub,
`endif
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);

   localparam int             CW      = cnt_width(WIDTH);
   localparam logic [CW-1:0]  CNT_MAX = CW'(WIDTH - 1);

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_sh_q, a_sh_d;
   logic [WIDTH-1:0] b_sh_q, b_sh_d;
   logic [WIDTH-1:0] part_q, part_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic             carry_q, carry_d;
   logic             cout_q, cout_d;
   logic [CW-1:0]    cnt_q, cnt_d;

   logic             fa_s, fa_co;
   logic             sub_sel;
   logic [WIDTH-1:0] part_next;

`ifdef SERIAL_ADDER_SUB_EN
   assign sub_sel = sub;
`else
   assign sub_sel = 1'b0;
`endif

   full_adder u_fa (
      .a  (a_sh_q[0]),
      .b  (b_sh_q[0]),
      .ci (carry_q),
      .s  (fa_s),
      .co (fa_co)
   );

   // Each new sum bit enters at the MSB; after WIDTH shifts bit 0 sits at the LSB.
   assign part_next = {fa_s, part_q[WIDTH-1:1]};

   always_comb begin
      state_d = state_q;
      a_sh_d  = a_sh_q;
      b_sh_d  = b_sh_q;
      part_d  = part_q;
      sum_d   = sum_q;
      carry_d = carry_q;
      cout_d  = cout_q;
      cnt_d   = cnt_q;

      unique case (state_q)
         IDLE: begin
            if (start) begin
               a_sh_d  = a;
               // Subtraction is a + ~b + 1: invert B and force the carry in.
               b_sh_d  = sub_sel ? ~b : b;
               carry_d = sub_sel ? 1'b1 : cin;
               part_d  = '0;
               cnt_d   = '0;
               state_d = ADD;
            end
         end
         ADD: begin
            part_d  = part_next;
            a_sh_d  = a_sh_q >> 1;
            b_sh_d  = b_sh_q >> 1;
            carry_d = fa_co;
            if (cnt_q == CNT_MAX) begin
               sum_d   = part_next;
               cout_d  = fa_co;
               state_d = DONE;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         a_sh_q  <= '0;
         b_sh_q  <= '0;
         part_q  <= '0;
         sum_q   <= '0;
         carry_q <= 1'b0;
         cout_q  <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         a_sh_q  <= a_sh_d;
         b_sh_q  <= b_sh_d;
         part_q  <= part_d;
         sum_q   <= sum_d;
         carry_q <= carry_d;
         cout_q  <= cout_d;
         cnt_q   <= cnt_d;
      end
   end

   assign busy = (state_q != IDLE);
   assign done = (state_q == DONE);
   assign sum  = sum_q;
   assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// tb/tb_serial_adder_ctrl.sv - self-checking bench for serial_adder_ctrl
// Purpose : directed and random operations checked against an arithmetic model.
// Ports   : none (top-level bench). SERIAL_ADDER_SUB_EN enables the sub tests.
module tb_serial_adder_ctrl;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         start;
   logic [W-1:0] a, b;
   logic         cin;
   logic         busy, done, cout;
   logic [W-1:0] sum;
`ifdef SERIAL_ADDER_SUB_EN
   logic         sub;
`endif

   int           n_checks = 0;
   int           n_fail   = 0;
   logic [W:0]   last_res;

   always #5 clk = ~clk;

   serial_adder_ctrl #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .a     (a),
      .b     (b),
      .cin   (cin),
`ifdef SERIAL_ADDER_SUB_EN
      .sub   (sub),
`endif
      .busy  (busy),
      .done  (done),
      .sum   (sum),
      .cout  (cout)
   );

   // Reference: {cout,sum} = a+b+cin, or for subtraction sum=a-b, cout=no borrow.
   function automatic logic [W:0] ref_op(input logic [W-1:0] x, input logic [W-1:0] y,
                                         input logic c, input logic s);
      int unsigned  tot;
      logic [W-1:0] diff;
      if (s) begin
         diff = x - y;
         return {(x >= y), diff};
      end
      tot = int'(x) + int'(y) + int'(c);
      return tot[W:0];
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic launch(input logic [W-1:0] x, input logic [W-1:0] y,
                         input logic c, input logic s);
      a = x; b = y; cin = c;
`ifdef SERIAL_ADDER_SUB_EN
      sub = s;
`endif
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   // One complete operation with cycle-exact checks of busy, done and the hold of sum.
   task automatic run_op(input string name, input logic [W-1:0] x, input logic [W-1:0] y,
                         input logic c, input logic s);
      logic [W:0] exp;
      exp = ref_op(x, y, c, s);
      launch(x, y, c, s);
      n_checks++;
      if (busy !== 1'b1) begin
         n_fail++;
         $display("FAIL %s busy_at_E0: busy=%0b expected 1", name, busy);
      end
      for (int k = 1; k <= W; k++) begin
         tick();
         n_checks++;
         if (k < W) begin
            if (done !== 1'b0 || {cout, sum} !== last_res || busy !== 1'b1) begin
               n_fail++;
               $display("FAIL %s hold_E%0d: done=%0b busy=%0b res=%h expected done=0 busy=1 res=%h",
                        name, k, done, busy, {cout, sum}, last_res);
            end
         end else begin
            if (done !== 1'b1 || {cout, sum} !== exp) begin
               n_fail++;
               $display("FAIL %s result_E%0d: done=%0b res=%h expected done=1 res=%h",
                        name, k, done, {cout, sum}, exp);
            end
         end
      end
      last_res = exp;
      tick();
      n_checks++;
      if (done !== 1'b0 || busy !== 1'b0 || {cout, sum} !== exp) begin
         n_fail++;
         $display("FAIL %s after_done: done=%0b busy=%0b res=%h expected done=0 busy=0 res=%h",
                  name, done, busy, {cout, sum}, exp);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
      sub = 1'b0;
`endif
      tick();
      tick();
      n_checks++;
      if (busy !== 1'b0 || done !== 1'b0 || sum !== '0 || cout !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_values: busy=%0b done=%0b sum=%h cout=%0b expected all 0",
                  busy, done, sum, cout);
      end
      rst_n = 1'b1;
      tick();
      tick();
      n_checks++;
      if (busy !== 1'b0 || done !== 1'b0) begin
         n_fail++;
         $display("FAIL idle_no_start: busy=%0b done=%0b expected 0 0", busy, done);
      end
      last_res = '0;
   endtask

   task automatic test_directed();
      run_op("add_5a_33", 8'h5A, 8'h33, 1'b0, 1'b0);
      run_op("add_ff_01", 8'hFF, 8'h01, 1'b0, 1'b0);
      run_op("add_ff_ff_c1", 8'hFF, 8'hFF, 1'b1, 1'b0);
      run_op("add_00_00", 8'h00, 8'h00, 1'b0, 1'b0);
   endtask

   task automatic test_start_ignored();
      logic [W:0] exp1, exp2;
      exp1 = ref_op(8'h40, 8'h22, 1'b0, 1'b0);
      exp2 = ref_op(8'h01, 8'h01, 1'b0, 1'b0);
      launch(8'h40, 8'h22, 1'b0, 1'b0);
      tick();
      tick();
      a = 8'h01; b = 8'h01; start = 1'b1;
      tick();
      start = 1'b0;
      n_checks++;
      if (busy !== 1'b1 || done !== 1'b0) begin
         n_fail++;
         $display("FAIL start_in_add: busy=%0b done=%0b expected 1 0", busy, done);
      end
      for (int k = 4; k <= 7; k++) tick();
      start = 1'b1;
      tick();
      n_checks++;
      if (done !== 1'b1 || {cout, sum} !== exp1) begin
         n_fail++;
         $display("FAIL start_ignored_result: done=%0b res=%h expected done=1 res=%h",
                  done, {cout, sum}, exp1);
      end
      last_res = exp1;
      tick();
      n_checks++;
      if (busy !== 1'b0 || done !== 1'b0) begin
         n_fail++;
         $display("FAIL start_in_done: busy=%0b done=%0b expected 0 0", busy, done);
      end
      tick();
      start = 1'b0;
      n_checks++;
      if (busy !== 1'b1) begin
         n_fail++;
         $display("FAIL restart_accept: busy=%0b expected 1", busy);
      end
      for (int k = 1; k <= W; k++) begin
         tick();
         n_checks++;
         if (k < W) begin
            if (done !== 1'b0 || {cout, sum} !== last_res) begin
               n_fail++;
               $display("FAIL restart_hold_E%0d: done=%0b res=%h expected done=0 res=%h",
                        k, done, {cout, sum}, last_res);
            end
         end else if (done !== 1'b1 || {cout, sum} !== exp2) begin
            n_fail++;
            $display("FAIL restart_result: done=%0b res=%h expected done=1 res=%h",
                     done, {cout, sum}, exp2);
         end
      end
      last_res = exp2;
      tick();
   endtask

   task automatic test_abort();
      launch(8'h12, 8'h34, 1'b1, 1'b0);
      for (int k = 1; k <= 4; k++) tick();
      rst_n = 1'b0;
      #1;
      n_checks++;
      if (busy !== 1'b0 || done !== 1'b0 || sum !== '0 || cout !== 1'b0) begin
         n_fail++;
         $display("FAIL abort_outputs: busy=%0b done=%0b sum=%h cout=%0b expected all 0",
                  busy, done, sum, cout);
      end
      tick();
      rst_n = 1'b1;
      last_res = '0;
      for (int k = 0; k < W + 3; k++) begin
         tick();
         n_checks++;
         if (done !== 1'b0 || busy !== 1'b0 || {cout, sum} !== last_res) begin
            n_fail++;
            $display("FAIL abort_quiet_%0d: done=%0b busy=%0b res=%h expected 0 0 %h",
                     k, done, busy, {cout, sum}, last_res);
         end
      end
      run_op("after_abort", 8'h12, 8'h34, 1'b1, 1'b0);
   endtask

   task automatic test_random();
      logic [W-1:0] x, y;
      logic         c, s;
      for (int i = 0; i < 16; i++) begin
         x = W'($urandom);
         y = W'($urandom);
         c = 1'($urandom_range(0, 1));
`ifdef SERIAL_ADDER_SUB_EN
         s = 1'($urandom_range(0, 1));
`else
         s = 1'b0;
`endif
         run_op($sformatf("rand_%0d", i), x, y, c, s);
      end
   endtask

`ifdef SERIAL_ADDER_SUB_EN
   task automatic test_sub();
      run_op("sub_10_01", 8'h10, 8'h01, 1'b0, 1'b1);
      run_op("sub_01_02", 8'h01, 8'h02, 1'b1, 1'b1);
      run_op("sub_off_add", 8'h5A, 8'h33, 1'b1, 1'b0);
   endtask
`endif

   initial begin
      test_reset();
      test_directed();
      test_start_ignored();
      test_abort();
      test_random();
`ifdef SERIAL_ADDER_SUB_EN
      test_sub();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
